bp_table_update_scheduler: RTL and testbench

Schedules the single-ported branch-predictor counter table (PHT) shared by fetch-stage lookups and EX-stage counter updates. It buffers 2-bit counter updates from branch resolution in a small FIFO and arbitrates the table port each cycle, with reads favoured and a starvation guard for writes. After reset, or on request, it sweeps every table entry to weakly-not-taken. It sits between the EX-stage branch resolution logic, the fetch-stage predictor lookup and the PHT SRAM macro.

---
 rtl/bp_table_update_scheduler.sv | 132 +++++++++++++
 tb/tb_bp_table_update_scheduler.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/bp_table_update_scheduler.sv
// Branch-predictor table port scheduler: sweeps the PHT to weakly-not-taken
// after reset or init_req, then arbitrates the single table port between
// fetch lookups (favoured) and queued EX-stage counter updates, with a
// starvation guard so queued updates make forward progress under read load.
module bp_table_update_scheduler #(
  parameter int INDEX_W    = 10,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       upd_valid,
  input  logic [INDEX_W-1:0]         upd_index,
  input  logic [1:0]                 upd_counter,
  output logic                       upd_ready,
  output logic                       stall_req,
  input  logic                       init_req,
  input  logic                       rd_req,
  input  logic [INDEX_W-1:0]         rd_index,
  output logic                       rd_grant,
  output logic                       tbl_en,
  output logic                       tbl_we,
  output logic [INDEX_W-1:0]         tbl_addr,
  output logic [1:0]                 tbl_wdata,
  output logic                       init_done,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int ST_W  = $clog2(STARVE_MAX+1);
  localparam logic [INDEX_W-1:0] LAST_ADDR = '1;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t               state, state_nxt;
  logic [INDEX_W-1:0]   sweep_addr;
  logic [INDEX_W+1:0]   fifo_mem [DEPTH];   // {index, counter}
  logic [PTR_W-1:0]     head, tail;
  logic [CNT_W-1:0]     count;
  logic [ST_W-1:0]      starve_cnt;
  logic                 fifo_empty, fifo_full, wr_sel, push;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(DEPTH));
  assign push       = upd_valid && upd_ready;
  assign stall_req  = !upd_ready;
  assign init_done  = (state == S_RUN);
  assign fifo_count = count;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_INIT;
    else        state <= state_nxt;
  end

  // Next state, port arbitration and table control
  always_comb begin
    state_nxt = state;
    tbl_en    = 1'b0;
    tbl_we    = 1'b0;
    tbl_addr  = '0;
    tbl_wdata = 2'b00;
    rd_grant  = 1'b0;
    upd_ready = 1'b0;
    wr_sel    = 1'b0;
    case (state)
      S_INIT: begin
        tbl_en    = 1'b1;
        tbl_we    = 1'b1;
        tbl_addr  = sweep_addr;
        tbl_wdata = 2'b01;
        if (!init_req && sweep_addr == LAST_ADDR) state_nxt = S_RUN;
      end
      S_RUN: begin
        upd_ready = !fifo_full;
        // Reads win unless the queue is full or the head has waited too long
        wr_sel = !fifo_empty &&
                 (!rd_req || fifo_full || starve_cnt == ST_W'(STARVE_MAX));
        if (wr_sel) begin
          tbl_en    = 1'b1;
          tbl_we    = 1'b1;
          tbl_addr  = fifo_mem[head][INDEX_W+1:2];
          tbl_wdata = fifo_mem[head][1:0];
        end else if (rd_req) begin
          tbl_en   = 1'b1;
          tbl_addr = rd_index;
          rd_grant = 1'b1;
        end
        if (init_req) state_nxt = S_INIT;
      end
      default: state_nxt = S_INIT;
    endcase
  end

  // Sweep address, FIFO pointers/occupancy and starvation counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_addr <= '0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      starve_cnt <= '0;
    end else if (state == S_INIT) begin
      sweep_addr <= (init_req || sweep_addr == LAST_ADDR) ? '0 : sweep_addr + 1'b1;
    end else if (init_req) begin
      // Flush: any write granted this cycle still reaches the table
      sweep_addr <= '0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      starve_cnt <= '0;
    end else begin
      if (push)   tail <= tail + PTR_W'(1);
      if (wr_sel) head <= head + PTR_W'(1);
      case ({push, wr_sel})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_sel)                     starve_cnt <= '0;
      else if (rd_req && !fifo_empty) starve_cnt <= starve_cnt + 1'b1;
      else                            starve_cnt <= '0;
    end
  end

  // Update storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (state == S_RUN && !init_req && push) fifo_mem[tail] <= {upd_index, upd_counter};
  end

endmodule

// File: tb/tb_bp_table_update_scheduler.sv
// Randomized bench for bp_table_update_scheduler against a queue-based
// reference model of the sweep / arbitration rules.
module tb_bp_table_update_scheduler;
  localparam int IW      = 4;
  localparam int DEPTH   = 4;
  localparam int SMAX    = 8;
  localparam int ENTRIES = 1 << IW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          upd_valid = 1'b0;
  logic [IW-1:0] upd_index = '0;
  logic [1:0]    upd_counter = '0;
  logic          upd_ready, stall_req;
  logic          init_req = 1'b0;
  logic          rd_req = 1'b0;
  logic [IW-1:0] rd_index = '0;
  logic          rd_grant, tbl_en, tbl_we, init_done;
  logic [IW-1:0] tbl_addr;
  logic [1:0]    tbl_wdata;
  logic [2:0]    fifo_count;

  bp_table_update_scheduler #(.INDEX_W(IW), .DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_counter(upd_counter),
    .upd_ready(upd_ready), .stall_req(stall_req), .init_req(init_req),
    .rd_req(rd_req), .rd_index(rd_index), .rd_grant(rd_grant),
    .tbl_en(tbl_en), .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
    .init_done(init_done), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: sweeping flag + position, pending updates in arrival
  // order, and how many reads in a row have beaten a waiting update.
  bit             m_init;
  int             m_sweep;
  logic [IW+1:0]  m_q[$];
  int             m_streak;

  task automatic model_reset();
    m_init   = 1'b1;
    m_sweep  = 0;
    m_q.delete();
    m_streak = 0;
  endtask

  // One cycle: drive at negedge, check 1ns later, advance model to the
  // coming posedge, then wait for the next negedge.
  task automatic step(input int p_rd, input int p_upd, input int p_init_pm);
    logic          e_en, e_we, e_grant, e_ready;
    logic [IW-1:0] e_addr;
    logic [1:0]    e_wd;
    logic [IW+1:0] hd;
    bit            wr;
    int            pre;
    rd_req      = ($urandom_range(99) < p_rd);
    rd_index    = IW'($urandom_range(ENTRIES-1));
    upd_valid   = ($urandom_range(99) < p_upd);
    upd_index   = IW'($urandom_range(ENTRIES-1));
    upd_counter = 2'($urandom_range(3));
    init_req    = ($urandom_range(999) < p_init_pm);
    #1;
    e_en = 0; e_we = 0; e_grant = 0; e_ready = 0; e_addr = '0; e_wd = 2'b00; wr = 0;
    if (m_init) begin
      e_en = 1; e_we = 1; e_addr = IW'(m_sweep); e_wd = 2'b01;
    end else begin
      e_ready = (m_q.size() < DEPTH);
      wr = (m_q.size() > 0) && (!rd_req || m_q.size() == DEPTH || m_streak >= SMAX);
      if (wr) begin
        hd = m_q[0];
        e_en = 1; e_we = 1; e_addr = hd[IW+1:2]; e_wd = hd[1:0];
      end else if (rd_req) begin
        e_en = 1; e_addr = rd_index; e_grant = 1;
      end
    end
    chk("init_done",  32'(init_done),  32'(!m_init));
    chk("fifo_count", 32'(fifo_count), 32'(m_q.size()));
    chk("upd_ready",  32'(upd_ready),  32'(e_ready));
    chk("stall_req",  32'(stall_req),  32'(!e_ready));
    chk("rd_grant",   32'(rd_grant),   32'(e_grant));
    chk("tbl_en",     32'(tbl_en),     32'(e_en));
    chk("tbl_we",     32'(tbl_we),     32'(e_we));
    if (e_en) chk("tbl_addr",  32'(tbl_addr),  32'(e_addr));
    if (e_we) chk("tbl_wdata", 32'(tbl_wdata), 32'(e_wd));
    if (rst_n) begin
      if (m_init) begin
        if (init_req)                  m_sweep = 0;
        else if (m_sweep == ENTRIES-1) begin m_init = 0; m_sweep = 0; end
        else                           m_sweep++;
      end else begin
        pre = m_q.size();
        if (wr) void'(m_q.pop_front());
        if (init_req) begin
          m_q.delete(); m_streak = 0; m_init = 1; m_sweep = 0;
        end else begin
          if (upd_valid && e_ready) m_q.push_back({upd_index, upd_counter});
          if (wr)                       m_streak = 0;
          else if (rd_req && pre > 0)   m_streak++;
          else                          m_streak = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    repeat (2) step(50, 50, 0);          // held in reset
    rst_n = 1'b1;
    repeat (ENTRIES + 2) step(50, 50, 0); // full sweep and entry to RUN
    repeat (400) step(70, 40, 5);        // mixed traffic, occasional init_req
    repeat (100) step(100, 10, 0);       // sustained reads: starvation guard
    repeat (40) step(100, 100, 0);       // back-pressure with full queue
    step(100, 100, 1000);                // init_req with queue populated
    repeat (ENTRIES + 4) step(60, 50, 0);
    repeat (30) step(0, 50, 0);          // idle port: immediate writes
    step(50, 50, 1000);                  // restart sweep
    for (int k = 0; k < 2*ENTRIES && m_sweep != 7; k++) step(50, 50, 0);
    rst_n = 1'b0;                        // async reset between edges, mid-sweep
    model_reset();
    repeat (2) step(50, 50, 0);
    rst_n = 1'b1;
    repeat (ENTRIES + 2) step(50, 50, 0);
    repeat (300) step(80, 60, 3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
